ps2_host_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_host_rx_if.sv | 13 +
 rtl/ps2_rx_fifo.sv | 72 +++++++
 rtl/ps2_host_rx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_rx.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host receiver.
//   ps2_rx_state_t : deframer FSM states
//   ps2_err_t      : 2-bit error classification reported on err_code
//   PS2_FRAME_LEN  : start + 8 data + parity + stop
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_PARITY  = 2'b01,
    ERR_FRAME   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } ps2_err_t;

  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

endpackage

// File: rtl/ps2_host_rx_if.sv
// ps2_host_rx_if: byte handshake toward the system side.
//   cmd_rdy : receiver has a byte at the FIFO head
//   cmd     : head byte, meaningful only while cmd_rdy
//   cmd_ack : consumer takes the head byte when cmd_rdy & cmd_ack
// master = receiver (byte source), slave = consumer.
interface ps2_host_rx_if;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic       cmd_ack;

  modport master (output cmd_rdy, output cmd, input  cmd_ack);
  modport slave  (input  cmd_rdy, input  cmd, output cmd_ack);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous byte FIFO between the deframer and the system.
//   push/din  : write request; dropped when full unless a pop happens
//               in the same cycle (the pop frees the slot)
//   pop       : read request; ignored when empty
//   dout      : head entry, forced to 0 while empty
//   full/empty/count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module ps2_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import ps2_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 host receiver (device -> host path).
// Oversamples ps2_clk/ps2_data, deframes 11-bit frames on falling edges of
// the synchronised clock, checks stop and odd parity and queues good bytes.
//   clk, rst_n       : system clock, async active-low reset
//   ps2_clk/ps2_data : raw device lines (asynchronous)
//   cmd_if (master)  : cmd_rdy/cmd/cmd_ack byte handshake
//   error            : one-cycle pulse per rejected frame
//   err_code         : last error class (01 parity, 10 framing, 11 timeout)
//   overflow         : sticky, a good byte was dropped on a full FIFO
//   fifo_cnt         : FIFO occupancy
// Build option: define PS2_RX_TIMEOUT_EN to include the inter-bit watchdog
// (TIMEOUT_CYCLES); without it a stalled frame waits for more edges.
module ps2_host_rx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  ps2_host_rx_if.master                 cmd_if,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
  import ps2_pkg::*;

  ps2_rx_state_t          state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   error_q, error_d;
  ps2_err_t               err_code_q, err_code_d;
  logic                   overflow_q, overflow_d;

  logic     clk_s, data_s, bit_evt, timeout;
  logic     push, err_set;
  ps2_err_t err_val;
  logic     fifo_full, fifo_empty, fifo_pop;

  // Synchronisers and falling-edge detect
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d = clk_s;
  end

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign data_s  = dat_sync_q[SYNC_STAGES-1];
  assign bit_evt = clk_prev_q & ~clk_s;

  // Inter-bit watchdog
`ifdef PS2_RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  assign timeout = (state_q != IDLE) && (wdog_q == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    wdog_d = wdog_q + 1'b1;
    if (state_q == IDLE || bit_evt || timeout) wdog_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state plus frame datapath
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    if (bit_evt) begin
      case (state_q)
        IDLE: begin
          // A sampled 1 is a glitch, not a start bit
          if (!data_s) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          // LSB arrives first: after 8 right-shifts it lands in bit 0
          shreg_d = {data_s, shreg_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (timeout) state_d = IDLE;
  end

  // FSM: outputs (frame verdict)
  always_comb begin
    push    = 1'b0;
    err_set = 1'b0;
    err_val = ERR_NONE;
    if (timeout) begin
      err_set = 1'b1;
      err_val = ERR_TIMEOUT;
    end else if (state_q == STOP && bit_evt) begin
      if (!data_s) begin
        err_set = 1'b1;
        err_val = ERR_FRAME;
      end else if (^{shreg_q, par_q} != 1'b1) begin
        err_set = 1'b1;
        err_val = ERR_PARITY;
      end else begin
        push = 1'b1;
      end
    end
  end

  // Status flops
  assign fifo_pop = cmd_if.cmd_ack;

  always_comb begin
    error_d    = err_set;
    err_code_d = err_set ? err_val : err_code_q;
    // A coincident pop frees the slot, so only a push without pop is lost
    overflow_d = overflow_q | (push & fifo_full & ~(fifo_pop & ~fifo_empty));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      overflow_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shreg_q),
    .pop   (fifo_pop),
    .dout  (cmd_if.cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign cmd_if.cmd_rdy = ~fifo_empty;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// tb_ps2_host_rx: self-checking bench for ps2_host_rx. A queue-based model
// classifies each sent frame (framing, odd parity, FIFO room) and predicts
// the queue contents, error pulses, err_code and overflow. The PS/2 bit
// period is scaled down to 2*HP system cycles to keep the run short.
module tb_ps2_host_rx;
  import ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int TMO   = 200;
  localparam int HP    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          error;
  logic [1:0]    err_code;
  logic          overflow;
  logic [CW-1:0] fifo_cnt;

  ps2_host_rx_if cmd_if();

  ps2_host_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .cmd_if   (cmd_if),
    .error    (error),
    .err_code (err_code),
    .overflow (overflow),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Model state
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic [1:0] exp_code;
  int         exp_errs;
  int         err_cycles;
  int         n_cmp, n_bad;

  // Every cycle with error high counts; a good design gives one per bad frame
  always @(posedge clk) if (error === 1'b1) err_cycles++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    return ($countones(d) % 2 == 0);
  endfunction

  // Device side: data set while clock high, host samples on the falling edge.
  // ack_stop raises cmd_ack for exactly the cycle the stop-bit push registers.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit ack_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(HP);
      ps2_clk = 1'b0;
      if (ack_stop && i == 10) begin
        tick(SYNC);
        cmd_if.cmd_ack = 1'b1;
        tick(1);
        cmd_if.cmd_ack = 1'b0;
        tick(HP - SYNC - 1);
      end else begin
        tick(HP);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(2 * HP);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    if (!s) begin
      exp_code = 2'b10; exp_errs++;
    end else if ($countones({d, p}) % 2 == 0) begin
      exp_code = 2'b01; exp_errs++;
    end else if (exp_q.size() == DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      exp_q.push_back(d);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s);
    send_bits(frame_bits(d, p, s), 11, 1'b0);
    model_frame(d, p, s);
  endtask

  task automatic ack_one(input string tag);
    n_cmp++;
    if (cmd_if.cmd_rdy !== 1'b1 || cmd_if.cmd !== exp_q[0]) begin
      n_bad++;
      $display("FAIL %s pop: rdy=%b cmd=%h, want rdy=1 cmd=%h", tag, cmd_if.cmd_rdy, cmd_if.cmd, exp_q[0]);
    end
    cmd_if.cmd_ack = 1'b1;
    tick(1);
    cmd_if.cmd_ack = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) ack_one(tag);
    n_cmp++;
    if (cmd_if.cmd_rdy !== 1'b0 || fifo_cnt !== '0) begin
      n_bad++;
      $display("FAIL %s drained: rdy=%b cnt=%0d, want 0/0", tag, cmd_if.cmd_rdy, fifo_cnt);
    end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; cmd_if.cmd_ack = 1'b0;
    tick(2);
    exp_q.delete(); exp_ovf = 1'b0; exp_code = 2'b00;
  endtask

  task automatic test_reset();
    hard_reset();
    n_cmp++;
    if ({cmd_if.cmd_rdy, cmd_if.cmd, error, err_code, overflow, fifo_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b cmd=%h err=%b code=%b ovf=%b cnt=%0d, want all 0",
               cmd_if.cmd_rdy, cmd_if.cmd, error, err_code, overflow, fifo_cnt);
    end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_good();
    send(8'hAB, 1'b0, 1'b1);
    n_cmp++;
    if (cmd_if.cmd_rdy !== 1'b1 || cmd_if.cmd !== 8'hAB || fifo_cnt !== CW'(1) || err_cycles != 0) begin
      n_bad++;
      $display("FAIL good_ab: rdy=%b cmd=%h cnt=%0d errs=%0d, want 1 ab 1 0",
               cmd_if.cmd_rdy, cmd_if.cmd, fifo_cnt, err_cycles);
    end
    drain("good_ab");
    // ack while empty must not disturb the FIFO
    cmd_if.cmd_ack = 1'b1; tick(3); cmd_if.cmd_ack = 1'b0;
    send(8'h3C, 1'b1, 1'b1);
    n_cmp++;
    if (fifo_cnt !== CW'(exp_q.size()) || cmd_if.cmd !== 8'h3C) begin
      n_bad++;
      $display("FAIL ack_empty: cnt=%0d cmd=%h, want 1 3c", fifo_cnt, cmd_if.cmd);
    end
    drain("ack_empty");
  endtask

  task automatic test_parity();
    send(8'hAB, 1'b1, 1'b1);
    n_cmp++;
    if (err_cycles != exp_errs || err_code !== 2'b01 || fifo_cnt !== '0) begin
      n_bad++;
      $display("FAIL parity: err_cycles=%0d code=%b cnt=%0d, want %0d 01 0", err_cycles, err_code, fifo_cnt, exp_errs);
    end
    send(8'h1C, 1'b0, 1'b1);
    n_cmp++;
    if (cmd_if.cmd !== 8'h1C || fifo_cnt !== CW'(1) || err_code !== 2'b01) begin
      n_bad++;
      $display("FAIL after_parity: cmd=%h cnt=%0d code=%b, want 1c 1 01", cmd_if.cmd, fifo_cnt, err_code);
    end
    drain("after_parity");
  endtask

  task automatic test_framing();
    send(8'h55, 1'b1, 1'b0);
    n_cmp++;
    if (err_cycles != exp_errs || err_code !== 2'b10 || fifo_cnt !== '0) begin
      n_bad++;
      $display("FAIL framing: err_cycles=%0d code=%b cnt=%0d, want %0d 10 0", err_cycles, err_code, fifo_cnt, exp_errs);
    end
    // Framing beats parity when both are wrong
    send(8'h55, 1'b0, 1'b0);
    n_cmp++;
    if (err_code !== 2'b10 || err_cycles != exp_errs) begin
      n_bad++;
      $display("FAIL frame_prio: code=%b err_cycles=%0d, want 10 %0d", err_code, err_cycles, exp_errs);
    end
    // Glitch: falling edge with data high must leave the FSM idle
    ps2_data = 1'b1; tick(HP); ps2_clk = 1'b0; tick(HP); ps2_clk = 1'b1; tick(2 * HP);
    send(8'h12, 1'b1, 1'b1);
    n_cmp++;
    if (err_cycles != exp_errs || cmd_if.cmd !== 8'h12 || fifo_cnt !== CW'(1)) begin
      n_bad++;
      $display("FAIL glitch: err_cycles=%0d cmd=%h cnt=%0d, want %0d 12 1", err_cycles, cmd_if.cmd, fifo_cnt, exp_errs);
    end
    drain("glitch");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH + 1; i++) send(8'(i), good_par(8'(i)), 1'b1);
    n_cmp++;
    if (overflow !== exp_ovf || exp_ovf !== 1'b1 || fifo_cnt !== CW'(DEPTH) || cmd_if.cmd !== 8'h01) begin
      n_bad++;
      $display("FAIL overflow: ovf=%b cnt=%0d cmd=%h, want 1 %0d 01", overflow, fifo_cnt, cmd_if.cmd, DEPTH);
    end
    // Push coincident with pop while full
    n_cmp++;
    if (cmd_if.cmd !== exp_q[0]) begin
      n_bad++;
      $display("FAIL full_pop_head: cmd=%h, want %h", cmd_if.cmd, exp_q[0]);
    end
    send_bits(frame_bits(8'h06, good_par(8'h06), 1'b1), 11, 1'b1);
    void'(exp_q.pop_front());
    model_frame(8'h06, good_par(8'h06), 1'b1);
    n_cmp++;
    if (fifo_cnt !== CW'(DEPTH) || overflow !== 1'b1 || cmd_if.cmd !== exp_q[0]) begin
      n_bad++;
      $display("FAIL push_pop_full: cnt=%0d ovf=%b cmd=%h, want %0d 1 %h", fifo_cnt, overflow, cmd_if.cmd, DEPTH, exp_q[0]);
    end
    drain("overflow");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       p, s;
      int         kind;
      d    = 8'($urandom);
      kind = $urandom_range(0, 9);
      p    = (kind == 7 || kind == 9) ? ~good_par(d) : good_par(d);
      s    = (kind >= 8) ? 1'b0 : 1'b1;
      send(d, p, s);
      n_cmp++;
      if (fifo_cnt !== CW'(exp_q.size()) || err_code !== exp_code || err_cycles != exp_errs || overflow !== exp_ovf) begin
        n_bad++;
        $display("FAIL random[%0d] d=%h p=%b s=%b: cnt=%0d code=%b errs=%0d ovf=%b, want %0d %b %0d %b",
                 n, d, p, s, fifo_cnt, err_code, err_cycles, overflow, exp_q.size(), exp_code, exp_errs, exp_ovf);
      end
      for (int k = $urandom_range(0, 2); k > 0 && exp_q.size() > 0; k--) ack_one("random");
    end
    drain("random");
  endtask

  task automatic test_timeout();
    send_bits(frame_bits(8'h5A, 1'b1, 1'b1), 5, 1'b0);
    tick(TMO + 50);
`ifdef PS2_RX_TIMEOUT_EN
    exp_errs++; exp_code = 2'b11;
    n_cmp++;
    if (err_cycles != exp_errs || err_code !== 2'b11 || fifo_cnt !== '0) begin
      n_bad++;
      $display("FAIL timeout: err_cycles=%0d code=%b cnt=%0d, want %0d 11 0", err_cycles, err_code, fifo_cnt, exp_errs);
    end
    send(8'h1C, 1'b0, 1'b1);
    n_cmp++;
    if (cmd_if.cmd !== 8'h1C || fifo_cnt !== CW'(1) || err_cycles != exp_errs) begin
      n_bad++;
      $display("FAIL after_timeout: cmd=%h cnt=%0d errs=%0d, want 1c 1 %0d", cmd_if.cmd, fifo_cnt, err_cycles, exp_errs);
    end
    drain("after_timeout");
`else
    n_cmp++;
    if (err_cycles != exp_errs || err_code !== exp_code || fifo_cnt !== '0) begin
      n_bad++;
      $display("FAIL stall: err_cycles=%0d code=%b cnt=%0d, want %0d %b 0", err_cycles, err_code, fifo_cnt, exp_errs, exp_code);
    end
    // FSM is parked mid-frame; reset is the only way out
    hard_reset();
    rst_n = 1'b1;
    tick(4);
`endif
  endtask

  task automatic test_reset_mid();
    send(8'h21, good_par(8'h21), 1'b1);
    send(8'h7E, good_par(8'h7E), 1'b1);
    n_cmp++;
    if (fifo_cnt !== CW'(2)) begin
      n_bad++;
      $display("FAIL queued_two: cnt=%0d, want 2", fifo_cnt);
    end
    send_bits(frame_bits(8'h99, 1'b1, 1'b1), 4, 1'b0);
    ps2_data = 1'b0; tick(HP); ps2_clk = 1'b0; tick(3);
    hard_reset();
    n_cmp++;
    if ({cmd_if.cmd_rdy, cmd_if.cmd, error, err_code, overflow, fifo_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: rdy=%b cmd=%h err=%b code=%b ovf=%b cnt=%0d, want all 0",
               cmd_if.cmd_rdy, cmd_if.cmd, error, err_code, overflow, fifo_cnt);
    end
    rst_n = 1'b1;
    tick(4);
    send(8'hF0, 1'b1, 1'b1);
    n_cmp++;
    if (fifo_cnt !== CW'(1) || cmd_if.cmd !== 8'hF0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: cnt=%0d cmd=%h ovf=%b, want 1 f0 0", fifo_cnt, cmd_if.cmd, overflow);
    end
    drain("after_reset");
  endtask

  initial begin
    cmd_if.cmd_ack = 1'b0;
    exp_ovf = 1'b0; exp_code = 2'b00; exp_errs = 0; err_cycles = 0;
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_good();
    test_parity();
    test_framing();
    test_overflow();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
